halt_resume_controller: RTL

- Sequential counterpart to the halt-detect logic: consumes the combinational `halt` (EBREAK seen in ID) and handles the full stop/restart sequence.
- Freezes fetch, squashes the instruction behind the EBREAK, and waits for older instructions to retire from EX/MEM/WB.
- Reports `halted`, then waits for an external resume (or single-step) handshake.
- On release, redirects fetch to EBREAK PC + 4. Sits beside the hazard unit and drives the PC-stall and IF/ID-flush controls.

---
 rtl/halt_resume_controller_pkg.sv | 17 +
 rtl/halt_resume_controller_drain_counter.sv | 38 +++
 rtl/halt_resume_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/halt_resume_controller_pkg.sv
// Purpose: shared state encoding and drain-counter width for the halt/resume controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package halt_resume_controller_pkg;

   // Drain counter width; DRAIN_CYCLES is limited to 1..15 so DRAIN_CYCLES-1 fits.
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      HRC_RUN    = 3'd0,
      HRC_DRAIN  = 3'd1,
      HRC_HALTED = 3'd2,
      HRC_RESUME = 3'd3,
      HRC_STEP   = 3'd4
   } hrc_state_e;

endpackage

// File: rtl/halt_resume_controller_drain_counter.sv
// Purpose: loadable 4-bit down-counter with zero flag, times the pipeline drain.
// Latency: load/decrement take effect on the next clock edge; zero is combinational from the count.
// Backpressure: none; saturates at zero if decremented there.
// Ports: clk, rst (async, active-high); load/load_val (reload); dec (count down); zero (count == 0).
module halt_resume_controller_drain_counter
   import halt_resume_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/halt_resume_controller.sv
// Purpose: stops the pipeline on EBREAK, drains older instructions, waits for the debugger, restarts at EBREAK PC + 4.
// Latency: halt_req -> halted in DRAIN_CYCLES+1 cycles; request -> ack 1 cycle, then redirect, then fetch resumes.
// Backpressure: holds pc_stall for the whole stop sequence; resume/step are level requests held until resume_ack.
// Ports: clk, rst (async, active-high); halt_req/id_pc from the halting unit; resume_req/step_req/resume_ack
//        debugger handshake; pc_stall/flush_if_id/redirect/redirect_pc to the fetch stage; halted status.
// Optional: define HALT_STEP_EN to enable single-step (step_req) through the STEP state.
module halt_resume_controller
   import halt_resume_controller_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            halt_req,
   input  logic [XLEN-1:0] id_pc,
   input  logic            resume_req,
   input  logic            step_req,
   output logic            resume_ack,
   output logic            pc_stall,
   output logic            flush_if_id,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            halted
);

   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   hrc_state_e      state_q, state_d;
   logic [XLEN-1:0] ebreak_pc_q, ebreak_pc_d;
   logic            resume_ack_q, resume_ack_d;
   logic            redirect_q, redirect_d;
   logic            halted_q, halted_d;
   logic            cnt_load, cnt_dec, cnt_zero;
   logic            fetch_open;
   logic            go_req;

`ifdef HALT_STEP_EN
   logic            step_pend_q, step_pend_d;

   // Step wins over resume when both are requested.
   assign go_req     = resume_req || step_req;
   // STEP behaves like RUN for one cycle: one fetch, or a fresh halt if another EBREAK is in ID.
   assign fetch_open = (state_q == HRC_RUN) || (state_q == HRC_STEP);
`else
   logic            step_unused;

   assign step_unused = step_req;
   assign go_req      = resume_req;
   assign fetch_open  = (state_q == HRC_RUN);
`endif

   halt_resume_controller_drain_counter u_drain (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (DRAIN_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign redirect_pc = ebreak_pc_q + XLEN'(4);

   always_comb begin
      state_d      = state_q;
      ebreak_pc_d  = ebreak_pc_q;
      resume_ack_d = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
`ifdef HALT_STEP_EN
      step_pend_d  = step_pend_q;
`endif
      case (state_q)
         HRC_RUN: begin
            if (halt_req) begin
               ebreak_pc_d = id_pc;
               cnt_load    = 1'b1;
               state_d     = HRC_DRAIN;
            end
         end
         HRC_DRAIN: begin
            // halt_req is ignored here: the stalled EBREAK is still sitting in ID.
            if (cnt_zero) begin
               state_d = HRC_HALTED;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         HRC_HALTED: begin
            // The request is still high during the ack cycle; leaving on the registered
            // ack prevents it from being taken twice.
            if (resume_ack_q) begin
               state_d = HRC_RESUME;
            end else if (go_req) begin
               resume_ack_d = 1'b1;
`ifdef HALT_STEP_EN
               step_pend_d  = step_req;
`endif
            end
         end
         HRC_RESUME: begin
`ifdef HALT_STEP_EN
            state_d     = step_pend_q ? HRC_STEP : HRC_RUN;
            step_pend_d = 1'b0;
`else
            state_d = HRC_RUN;
`endif
         end
`ifdef HALT_STEP_EN
         HRC_STEP: begin
            // Without a new EBREAK, the instruction fetched now sits at redirect_pc;
            // it becomes the new restart base.
            ebreak_pc_d = halt_req ? id_pc : redirect_pc;
            cnt_load    = 1'b1;
            state_d     = HRC_DRAIN;
         end
`endif
         default: begin
            state_d = HRC_RUN;
         end
      endcase
      redirect_d = (state_d == HRC_RESUME);
      halted_d   = (state_d == HRC_HALTED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HRC_RUN;
         ebreak_pc_q  <= '0;
         resume_ack_q <= 1'b0;
         redirect_q   <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ebreak_pc_q  <= ebreak_pc_d;
         resume_ack_q <= resume_ack_d;
         redirect_q   <= redirect_d;
         halted_q     <= halted_d;
      end
   end

`ifdef HALT_STEP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_pend_q <= 1'b0;
      end else begin
         step_pend_q <= step_pend_d;
      end
   end
`endif

   // Stall and flush rise in the same cycle as halt_req so nothing behind the EBREAK is fetched.
   assign pc_stall    = !fetch_open || halt_req;
   assign flush_if_id = (fetch_open && halt_req) || redirect_q;
   assign resume_ack  = resume_ack_q;
   assign redirect    = redirect_q;
   assign halted      = halted_q;

endmodule
